// File: rtl/ahb3lite_sram_slave.sv
// AHB-Lite slave backed by a word-organised SRAM array.
// Handles byte/half/word transfers, optional wait states and the two-cycle ERROR response.
module ahb3lite_sram_slave #(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [HDATA_SIZE-1:0] HRDATA
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [HADDR_SIZE-1:0] MEM_BYTES = HADDR_SIZE'(MEM_DEPTH * 4);
  localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t          state, nxt;
  logic [3:0]      cnt;
  logic [AW-1:0]   addr_q;
  logic [3:0]      lanes_q;
  logic            wr_q;
  logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

  logic       accept, err, ready_int;
  logic [3:0] lanes;
  logic [HDATA_SIZE-1:0] lane_mask;
  state_t     acc_state;

  wire unused_sigs = ^{HBURST, HPROT, HTRANS[0]};

  // Only a slave that is itself ready can open a new data phase.
  assign accept = HSEL & HREADY & HTRANS[1] & ready_int;

  assign err = (HSIZE > 3'd2)
             | ((HSIZE == 3'd1) & HADDR[0])
             | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00))
             | (HADDR >= MEM_BYTES);

  always_comb begin
    lanes = 4'b1111;
    case (HSIZE)
      3'd0:    lanes = 4'b0001 << HADDR[1:0];
      3'd1:    lanes = HADDR[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b1111;
    endcase
  end

  assign acc_state = err ? S_ERR1 : ((WAIT_STATES > 0) ? S_WAIT : S_DATA);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      lanes_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        addr_q  <= HADDR[AW+1:2];
        lanes_q <= lanes;
        wr_q    <= HWRITE;
        cnt     <= WS_LOAD;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DATA, S_ERR2: nxt = accept ? acc_state : S_IDLE;
      S_WAIT:                 nxt = (cnt == 4'd0) ? S_DATA : S_WAIT;
      S_ERR1:                 nxt = S_ERR2;
      default:                nxt = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) lane_mask[8*i +: 8] = {8{lanes_q[i]}};
  end

  always_comb begin
    ready_int = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;
    case (state)
      S_WAIT: ready_int = 1'b0;
      S_DATA: HRDATA = mem[addr_q] & lane_mask;
      S_ERR1: begin ready_int = 1'b0; HRESP = 1'b1; end
      S_ERR2: HRESP = 1'b1;
      default: ;
    endcase
  end

  assign HREADYOUT = ready_int;

  // Commit on the edge that ends the write data phase; a reset on that edge drops it.
  always_ff @(posedge HCLK) begin
    if (!HRESET && state == S_DATA && wr_q) begin
      for (int i = 0; i < 4; i++)
        if (lanes_q[i]) mem[addr_q][8*i +: 8] <= HWDATA[8*i +: 8];
    end
  end
endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Directed bench: zero-wait slave driven from a vector table, wait-state slave by hand sequences.
module tb_ahb3lite_sram_slave;
  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        sel0, sel2;
  logic [31:0] HADDR, HWDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        rdy0, rdy2, resp0, resp2;
  logic [31:0] rdata0, rdata2;

  int errors = 0;
  int checks = 0;

  always #5 HCLK = ~HCLK;

  ahb3lite_sram_slave #(.WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel0), .HADDR(HADDR), .HWDATA(HWDATA),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HREADY(rdy0), .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rdata0));

  ahb3lite_sram_slave #(.WAIT_STATES(2)) dut2 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel2), .HADDR(HADDR), .HWDATA(HWDATA),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HREADY(rdy2), .HREADYOUT(rdy2), .HRESP(resp2), .HRDATA(rdata2));

  typedef struct {
    logic        sel, wr;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic [31:0] addr, wdata;
    logic        rdy, resp, chk_d;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10;

  task automatic add(input logic sel, input logic wr, input logic [2:0] size,
                     input logic [1:0] trans, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic rdy, input logic resp, input logic chk_d, input logic [31:0] rdata);
    vec_t v;
    v.sel = sel; v.wr = wr; v.size = size; v.trans = trans; v.addr = addr; v.wdata = wdata;
    v.rdy = rdy; v.resp = resp; v.chk_d = chk_d; v.rdata = rdata;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [2:0] size, input logic [1:0] trans,
                       input logic [31:0] addr);
    HWRITE = wr; HSIZE = size; HTRANS = trans; HADDR = addr;
  endtask

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESET = 1'b1; sel0 = 1'b0; sel2 = 1'b0;
    HADDR = '0; HWDATA = '0; HWRITE = 1'b0; HSIZE = 3'd0;
    HBURST = 3'd0; HPROT = 4'd0; HTRANS = IDLE;

    //   sel wr size trans addr          wdata         rdy resp chk rdata
    add(1, 1, 2, NSEQ, 32'h4,         32'h0,          1, 0, 0, 32'h0);
    add(1, 1, 0, NSEQ, 32'h4,         32'h0,          1, 0, 0, 32'h0);
    add(1, 0, 0, NSEQ, 32'h4,         32'h0000_00AA,  1, 0, 1, 32'h0000_00AA);
    add(1, 1, 0, NSEQ, 32'h5,         32'h0,          1, 0, 0, 32'h0);
    add(1, 0, 2, NSEQ, 32'h4,         32'h0000_BB00,  1, 0, 1, 32'h0000_BBAA);
    add(1, 1, 1, NSEQ, 32'h6,         32'h0,          1, 0, 0, 32'h0);
    add(1, 0, 2, NSEQ, 32'h4,         32'h1234_0000,  1, 0, 1, 32'h1234_BBAA);
    add(1, 0, 0, NSEQ, 32'h5,         32'h0,          1, 0, 1, 32'h0000_BB00);
    add(1, 0, 0, IDLE, 32'h0,         32'h0,          1, 0, 1, 32'h0);
    add(1, 1, 2, NSEQ, 32'h0,         32'h0,          1, 0, 0, 32'h0);
    add(1, 0, 0, IDLE, 32'h0,         32'h1122_3344,  1, 0, 1, 32'h0);
    add(1, 1, 2, NSEQ, 32'h2,         32'h0,          0, 1, 1, 32'h0);
    add(1, 0, 0, IDLE, 32'h0,         32'hFFFF_FFFF,  1, 1, 1, 32'h0);
    add(1, 1, 3, NSEQ, 32'h0,         32'hFFFF_FFFF,  0, 1, 1, 32'h0);
    add(1, 0, 0, IDLE, 32'h0,         32'hFFFF_FFFF,  1, 1, 1, 32'h0);
    add(1, 0, 2, NSEQ, 32'h0,         32'hFFFF_FFFF,  1, 0, 1, 32'h1122_3344);
    add(1, 1, 2, NSEQ, 32'h8,         32'h0,          1, 0, 0, 32'h0);
    add(1, 0, 2, NSEQ, 32'h8,         32'hDEAD_BEEF,  1, 0, 1, 32'hDEAD_BEEF);
    add(1, 0, 2, NSEQ, 32'd1024,      32'h0,          0, 1, 1, 32'h0);
    add(1, 0, 0, IDLE, 32'h0,         32'h0,          1, 1, 1, 32'h0);
    add(1, 0, 0, IDLE, 32'h0,         32'h0,          1, 0, 1, 32'h0);
    add(0, 1, 2, NSEQ, 32'h0,         32'h0,          1, 0, 1, 32'h0);
    add(1, 1, 2, BUSY, 32'h0,         32'h0,          1, 0, 1, 32'h0);
    add(1, 0, 1, NSEQ, 32'h1,         32'h0,          0, 1, 1, 32'h0);
    add(1, 0, 0, IDLE, 32'h0,         32'h0,          1, 1, 1, 32'h0);
    add(1, 0, 2, NSEQ, 32'h0,         32'h0,          1, 0, 1, 32'h1122_3344);
    add(1, 0, 0, IDLE, 32'h0,         32'h0,          1, 0, 1, 32'h0);

    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    chk("reset_ready0", {31'b0, rdy0}, 32'h1);
    chk("reset_resp0",  {31'b0, resp0}, 32'h0);
    chk("reset_rdata0", rdata0, 32'h0);
    chk("reset_ready2", {31'b0, rdy2}, 32'h1);

    foreach (vecs[k]) begin
      sel0 = vecs[k].sel; HWDATA = vecs[k].wdata;
      drive(vecs[k].wr, vecs[k].size, vecs[k].trans, vecs[k].addr);
      tick();
      chk($sformatf("vec%0d_ready", k), {31'b0, rdy0}, {31'b0, vecs[k].rdy});
      chk($sformatf("vec%0d_resp", k), {31'b0, resp0}, {31'b0, vecs[k].resp});
      if (vecs[k].chk_d) chk($sformatf("vec%0d_rdata", k), rdata0, vecs[k].rdata);
    end
    sel0 = 1'b0;

    // Two wait states per transfer; HWDATA junk during WAIT must not land.
    sel2 = 1'b1; HWDATA = 32'hBAD0_BAD0;
    drive(1, 2, NSEQ, 32'h4);
    tick(); chk("ws_w_wait1", {31'b0, rdy2}, 32'h0);
    tick(); chk("ws_w_wait2", {31'b0, rdy2}, 32'h0);
    tick(); chk("ws_w_data", {30'b0, rdy2, resp2}, 32'h2);
    HWDATA = 32'h1234_BBAA;
    drive(0, 2, NSEQ, 32'h4);
    tick(); chk("ws_r_wait1", {31'b0, rdy2}, 32'h0);
    HWDATA = 32'hFFFF_FFFF; drive(0, 0, IDLE, 32'h0);
    tick(); chk("ws_r_wait2", {31'b0, rdy2}, 32'h0);
    tick(); chk("ws_r_ready", {30'b0, rdy2, resp2}, 32'h2);
    chk("ws_r_data", rdata2, 32'h1234_BBAA);
    tick(); chk("ws_idle", {31'b0, rdy2}, 32'h1);

    // Reset in the first wait cycle aborts the write.
    HWDATA = 32'h5555_5555;
    drive(1, 2, NSEQ, 32'h4);
    tick(); chk("rst_wait1", {31'b0, rdy2}, 32'h0);
    HRESET = 1'b1; drive(0, 0, IDLE, 32'h0);
    tick(); chk("rst_ready", {30'b0, rdy2, resp2}, 32'h2);
    chk("rst_rdata", rdata2, 32'h0);
    HRESET = 1'b0;
    drive(0, 2, NSEQ, 32'h4);
    tick(); chk("rst_r_wait1", {31'b0, rdy2}, 32'h0);
    drive(0, 0, IDLE, 32'h0);
    tick(); chk("rst_r_wait2", {31'b0, rdy2}, 32'h0);
    tick(); chk("rst_r_data", rdata2, 32'h1234_BBAA);
    sel2 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
